// File: rtl/audvid_pkg.sv
// Shared constants and the loader state encoding for the AudVid asset path.
package audvid_pkg;

  localparam int SD_BLOCK_BYTES = 512;
  localparam int FIFO_REQ_FREE  = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TILE_REQ,
    ST_TILE_RX,
    ST_AUDIO_WAIT,
    ST_AUDIO_REQ,
    ST_AUDIO_RX,
    ST_DONE
  } ld_state_e;

endpackage

// File: rtl/audvid_word_fifo.sv
// First-word-fall-through 16-bit FIFO; head reads as zero while empty.
module audvid_word_fifo #(
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [15:0]   wdata,
  input  logic          pop,
  output logic [15:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? 16'h0 : mem_q[rp_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata;
  end

endmodule

// File: rtl/sd_asset_loader.sv
// SD block loader: tile set into tile memory, then audio into a sample FIFO.
// Define AUDVID_AUDIO_LOOP_EN to replay the audio blocks indefinitely.
module sd_asset_loader
  import audvid_pkg::*;
#(
  parameter  int TILE_COUNT   = 32,
  parameter  int TILE_DIM     = 16,
  parameter  int PIX_BYTES    = 2,
  parameter  int TILE_BASE    = 0,
  parameter  int AUDIO_BASE   = 64,
  parameter  int AUDIO_BLOCKS = 1024,
  parameter  int FIFO_DEPTH   = 512,
  localparam int TILE_BYTES   = TILE_COUNT * TILE_DIM * TILE_DIM * PIX_BYTES,
  localparam int TA_W         = $clog2(TILE_BYTES)
) (
  input  logic            MasterCLK,
  input  logic            Reset,
  input  logic            start,
  output logic            rd_req,
  output logic [31:0]     rd_addr,
  input  logic            rd_ack,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            tile_we,
  output logic [TA_W-1:0] tile_addr,
  output logic [7:0]      tile_wdata,
  output logic [15:0]     sample,
  output logic            sample_valid,
  input  logic            sample_ready,
  output logic            busy,
  output logic            tiles_ready,
  output logic            overflow
);

  localparam int TILE_BLKS = TILE_BYTES / SD_BLOCK_BYTES;
  localparam int FCW       = $clog2(FIFO_DEPTH) + 1;
`ifdef AUDVID_AUDIO_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  ld_state_e       state_q, state_d;
  logic [31:0]     blk_cnt_q, blk_cnt_d;
  logic [8:0]      byte_cnt_q, byte_cnt_d;
  logic [TA_W-1:0] tcnt_q, tcnt_d;
  logic [TA_W-1:0] taddr_q, taddr_d;
  logic            tile_we_q, tile_we_d;
  logic [7:0]      twdata_q, twdata_d;
  logic [7:0]      low_q, low_d;
  logic            rd_req_q, rd_req_d;
  logic [31:0]     rd_addr_q, rd_addr_d;
  logic            trdy_q, trdy_d;
  logic            ovf_q, ovf_d;

  logic            start_ok;
  logic            in_rx;
  logic            blk_end;
  logic            tile_last;
  logic            audio_last;
  logic            room_ok;
  logic            push;
  logic            pop;
  logic            f_full;
  logic            f_empty;
  logic [FCW-1:0]  f_count;
  logic [15:0]     f_rdata;

  assign start_ok = start &&
    (state_q == ST_IDLE || state_q == ST_DONE);
  assign in_rx = state_q == ST_TILE_RX ||
    state_q == ST_AUDIO_RX;
  assign blk_end = in_rx && in_valid &&
    byte_cnt_q == 9'(SD_BLOCK_BYTES - 1);
  assign tile_last  = blk_cnt_q == 32'(TILE_BLKS - 1);
  assign audio_last = blk_cnt_q == 32'(AUDIO_BLOCKS - 1);
  // registered count only: a same-cycle pop is seen next cycle
  assign room_ok = (32'(FIFO_DEPTH) - 32'(f_count)) >=
    32'(FIFO_REQ_FREE);

  assign push = state_q == ST_AUDIO_RX && in_valid &&
    byte_cnt_q[0];
  assign pop  = !f_empty && sample_ready;

  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_TILE_REQ;
      end
      ST_TILE_REQ: begin
        if (rd_ack) state_d = ST_TILE_RX;
      end
      ST_TILE_RX: begin
        if (blk_end)
          state_d = tile_last ? ST_AUDIO_WAIT : ST_TILE_REQ;
      end
      ST_AUDIO_WAIT: begin
        if (room_ok) state_d = ST_AUDIO_REQ;
      end
      ST_AUDIO_REQ: begin
        if (rd_ack) state_d = ST_AUDIO_RX;
      end
      ST_AUDIO_RX: begin
        if (blk_end) begin
          if (audio_last && !LOOP_EN) state_d = ST_DONE;
          else                        state_d = ST_AUDIO_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    blk_cnt_d  = blk_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tcnt_d     = tcnt_q;
    taddr_d    = taddr_q;
    tile_we_d  = 1'b0;
    twdata_d   = twdata_q;
    low_d      = low_q;
    trdy_d     = trdy_q;
    ovf_d      = ovf_q;
    rd_addr_d  = rd_addr_q;
    if (start_ok) begin
      blk_cnt_d = '0;
      tcnt_d    = '0;
      taddr_d   = '0;
      trdy_d    = 1'b0;
      ovf_d     = 1'b0;
    end
    if (rd_ack && (state_q == ST_TILE_REQ ||
                   state_q == ST_AUDIO_REQ))
      byte_cnt_d = '0;
    if (in_rx && in_valid) byte_cnt_d = byte_cnt_q + 9'd1;
    if (state_q == ST_TILE_RX && in_valid) begin
      tile_we_d = 1'b1;
      taddr_d   = tcnt_q;
      twdata_d  = in_data;
      tcnt_d    = tcnt_q + TA_W'(1);
    end
    if (state_q == ST_AUDIO_RX && in_valid && !byte_cnt_q[0])
      low_d = in_data;
    if (blk_end) begin
      blk_cnt_d = blk_cnt_q + 32'd1;
      if (state_q == ST_TILE_RX && tile_last) begin
        blk_cnt_d = '0;
        trdy_d    = 1'b1;
      end
      if (state_q == ST_AUDIO_RX && audio_last && LOOP_EN)
        blk_cnt_d = '0;
    end
    if (in_valid && !in_rx) ovf_d = 1'b1;
    if (push && f_full)     ovf_d = 1'b1;
    rd_req_d = state_d == ST_TILE_REQ ||
      state_d == ST_AUDIO_REQ;
    if (state_d == ST_TILE_REQ)
      rd_addr_d = 32'(TILE_BASE) + blk_cnt_d;
    else if (state_d == ST_AUDIO_REQ)
      rd_addr_d = 32'(AUDIO_BASE) + blk_cnt_d;
  end

  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) begin
      blk_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tcnt_q     <= '0;
      taddr_q    <= '0;
      tile_we_q  <= 1'b0;
      twdata_q   <= '0;
      low_q      <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      trdy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      blk_cnt_q  <= blk_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tcnt_q     <= tcnt_d;
      taddr_q    <= taddr_d;
      tile_we_q  <= tile_we_d;
      twdata_q   <= twdata_d;
      low_q      <= low_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      trdy_q     <= trdy_d;
      ovf_q      <= ovf_d;
    end
  end

  audvid_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (MasterCLK),
    .rst   (Reset),
    .flush (start_ok),
    .push  (push),
    .wdata ({in_data, low_q}),
    .pop   (pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign rd_req       = rd_req_q;
  assign rd_addr      = rd_addr_q;
  assign tile_we      = tile_we_q;
  assign tile_addr    = taddr_q;
  assign tile_wdata   = twdata_q;
  assign sample       = f_rdata;
  assign sample_valid = !f_empty;
  assign busy         = !(state_q == ST_IDLE ||
                          state_q == ST_DONE);
  assign tiles_ready  = trdy_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_sd_asset_loader.sv
// Scoreboard bench for sd_asset_loader with random SD byte streams.
module tb_sd_asset_loader;

  localparam int TA_W = 14;
  localparam int NBLK = 32;

  logic            clk = 1'b0;
  logic            Reset;
  logic            start;
  logic            rd_req;
  logic [31:0]     rd_addr;
  logic            rd_ack;
  logic [7:0]      in_data;
  logic            in_valid;
  logic            tile_we;
  logic [TA_W-1:0] tile_addr;
  logic [7:0]      tile_wdata;
  logic [15:0]     sample;
  logic            sample_valid;
  logic            sample_ready;
  logic            busy;
  logic            tiles_ready;
  logic            overflow;

  int checks = 0;
  int errors = 0;
  int tile_idx = 0;
  bit rnd_rdy = 1'b0;
  logic [7:0] lo_b;
  logic [TA_W+7:0] tile_q[$];
  logic [15:0] samp_q[$];

  always #5 clk = ~clk;

  sd_asset_loader #(
    .AUDIO_BLOCKS (3)
  ) dut (
    .MasterCLK    (clk),
    .Reset        (Reset),
    .start        (start),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .tile_we      (tile_we),
    .tile_addr    (tile_addr),
    .tile_wdata   (tile_wdata),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .tiles_ready  (tiles_ready),
    .overflow     (overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) sample_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic rst_chk();
    chk("r_rd_req", rd_req, 0);
    chk("r_rd_addr", rd_addr, 0);
    chk("r_tile_we", tile_we, 0);
    chk("r_tile_addr", tile_addr, 0);
    chk("r_tile_wdata", tile_wdata, 0);
    chk("r_sample", sample, 0);
    chk("r_sample_valid", sample_valid, 0);
    chk("r_busy", busy, 0);
    chk("r_tiles_ready", tiles_ready, 0);
    chk("r_overflow", overflow, 0);
  endtask

  // Answer one request: check address, ack, then stream nbytes.
  task automatic serve(input int exp_addr, input bit is_tile,
                       input bit last_t, input bit first_a,
                       input bit inj, input int nbytes);
    int n = 0;
    logic [7:0] b;
    while (!rd_req && n < 3000) begin
      tick();
      n++;
    end
    chk("req_seen", rd_req, 1);
    chk("rd_addr", rd_addr, exp_addr);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    chk("req_drop", rd_req, 0);
    for (int i = 0; i < nbytes; i++) begin
      while ($urandom_range(0, 7) == 0) tick();
      b = 8'($urandom);
      if (first_a && i == 0) b = 8'h34;
      if (first_a && i == 1) b = 8'h12;
      if (is_tile) begin
        tile_q.push_back({TA_W'(tile_idx), b});
        tile_idx++;
      end else if (i % 2 == 0) begin
        lo_b = b;
      end else begin
        samp_q.push_back({b, lo_b});
      end
      in_data  = b;
      in_valid = 1'b1;
      if (inj && i == 200) start = 1'b1;
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      if (inj && i == 200) chk("busy_inj", busy, 1);
      if (is_tile && last_t && i >= 510)
        chk("tiles_ready", tiles_ready, 32'(i == 511));
      if (first_a && i == 0) chk("sv_early", sample_valid, 0);
      if (first_a && i == 1) begin
        chk("sv_pair", sample_valid, 1);
        chk("pair", sample, 16'h1234);
      end
    end
  endtask

  logic [TA_W+7:0] te;
  logic [15:0]     se;
  always @(negedge clk) begin
    if (tile_we) begin
      if (tile_q.size() == 0) begin
        chk("tile_extra", 1, 0);
      end else begin
        te = tile_q.pop_front();
        chk("tile_addr", tile_addr, te[TA_W+7:8]);
        chk("tile_data", tile_wdata, te[7:0]);
      end
    end
    if (sample_valid && sample_ready && !Reset) begin
      if (samp_q.size() == 0) begin
        chk("samp_extra", 1, 0);
      end else begin
        se = samp_q.pop_front();
        chk("sample", sample, se);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    rd_ack = 1'b0;
    in_data = 8'h0;
    in_valid = 1'b0;
    sample_ready = 1'b0;
    #12;
    rst_chk();
    @(posedge clk);
    #1;
    Reset = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ovf_idle", overflow, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovf_clr", overflow, 0);
    chk("busy_run", busy, 1);
    for (int k = 0; k < NBLK; k++)
      serve(k, 1'b1, k == NBLK - 1, 1'b0, k == 2, 512);
    tick();
    chk("tile_left", tile_q.size(), 0);
    serve(64, 1'b0, 1'b0, 1'b1, 1'b0, 512);
    serve(65, 1'b0, 1'b0, 1'b0, 1'b0, 512);
    repeat (20) tick();
    chk("full_no_req", rd_req, 0);
    chk("full_valid", sample_valid, 1);
    sample_ready = 1'b1;
    repeat (255) tick();
    sample_ready = 1'b0;
    repeat (20) tick();
    chk("pop255_no_req", rd_req, 0);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    rnd_rdy = 1'b1;
    serve(66, 1'b0, 1'b0, 1'b0, 1'b0, 512);
    chk("ovf_audio", overflow, 0);
`ifdef AUDVID_AUDIO_LOOP_EN
    begin
      int n = 0;
      while (!rd_req && n < 3000) begin
        tick();
        n++;
      end
      chk("loop_req", rd_req, 1);
      chk("loop_addr", rd_addr, 64);
      chk("loop_busy", busy, 1);
    end
    #2;
    Reset = 1'b1;
    #1;
    rst_chk();
    tick();
    Reset = 1'b0;
    samp_q.delete();
    rnd_rdy = 1'b0;
    sample_ready = 1'b0;
`else
    chk("done_busy", busy, 0);
    chk("done_tiles", tiles_ready, 1);
    begin
      int n = 0;
      while (samp_q.size() != 0 && n < 3000) begin
        tick();
        n++;
      end
      tick();
      chk("drain_left", samp_q.size(), 0);
      chk("drain_empty", sample_valid, 0);
    end
`endif
    tile_idx = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_trdy", tiles_ready, 0);
    serve(0, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    tick();
    #2;
    Reset = 1'b1;
    #1;
    rst_chk();
    tick();
    Reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rereq", rd_req, 1);
    chk("rereq_addr", rd_addr, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_asset_loader.md
# sd_asset_loader

Parametrised loader that sits between the SD SPI block reader and the AudVid tile store and I2S path. On a start pulse it fetches the tile set as whole 512-byte SD blocks and writes it byte-by-byte into tile memory. It then streams audio blocks into an internal sample FIFO, issuing block requests only when the FIFO can absorb a full block, since the SD byte stream has no backpressure.

## Interface
- TILE_COUNT, 32: number of tiles.
- TILE_DIM, 16: tile edge in pixels.
- PIX_BYTES, 2: bytes per pixel.
- TILE_BASE, 0: first SD block of tile data.
- AUDIO_BASE, 64: first SD block of audio data.
- AUDIO_BLOCKS, 1024: audio length in blocks, ≥1.
- FIFO_DEPTH, 512: audio FIFO depth in 16-bit words; power of 2, ≥256.
- Derived: TILE_BYTES = TILE_COUNT·TILE_DIM²·PIX_BYTES (must be a multiple of 512, nonzero); TA_W = clog2(TILE_BYTES).
- MasterCLK  in  1  sole clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- rd_req  out  1  block request, held until acknowledged.
- rd_addr  out  32  SD block address, stable while rd_req is high.
- rd_ack  in  1  one-cycle acknowledge from the SD reader.
- in_data  in  8  byte from the SD reader.
- in_valid  in  1  one-cycle byte strobe.
- tile_we  out  1  tile memory write strobe.
- tile_addr  out  TA_W  linear byte offset into tile memory.
- tile_wdata  out  8  tile byte.
- sample  out  16  FIFO head, little-endian signed PCM.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer pop.
- busy  out  1  not in IDLE/DONE.
- tiles_ready  out  1  all tile bytes written.
- overflow  out  1  sticky error flag.

## Operation
- States: IDLE, TILE_REQ, TILE_RX, AUDIO_WAIT, AUDIO_REQ, AUDIO_RX, DONE.
- IDLE + start → TILE_REQ. Clears blk_cnt, tile_addr, tiles_ready, overflow, and the FIFO.
- Request states: rd_req=1 with rd_addr = base + blk_cnt. rd_ack → the matching RX state with byte_cnt=0.
- In RX states, each in_valid increments byte_cnt (9-bit). The 512th byte ends the block and increments blk_cnt.
- TILE_RX: each byte produces a tile write at tile_addr, then tile_addr increments. After the last tile block, tiles_ready=1, blk_cnt=0, and the FSM moves to AUDIO_WAIT. Otherwise it returns to TILE_REQ.
- AUDIO_WAIT: when FIFO free words ≥ 256, go to AUDIO_REQ.
- AUDIO_RX: even-index bytes are latched as the low byte. Odd-index bytes push {in_data, low} into the FIFO.
- At the end of an audio block: if blk_cnt == AUDIO_BLOCKS, apply the end-of-audio rule below; otherwise go to AUDIO_WAIT.
- in_valid outside RX states is ignored and sets overflow.
- A push while the FIFO is full is dropped and sets overflow.
- Pop happens on sample_valid && sample_ready.
- Simultaneous push and pop: count unchanged, both take effect.
- start while busy is ignored.
- Reset mid-operation aborts immediately. rd_req drops and all state returns to reset values; no pending block is resumed.

## Timing
- Reset values: rd_req 0, rd_addr 0, tile_we 0, tile_addr 0, tile_wdata 0, sample 0, sample_valid 0, busy 0, tiles_ready 0, overflow 0. The FSM is in IDLE.
- start → rd_req high on the next edge.
- rd_ack edge → rd_req low in the same registered update.
- Tile write latency is 1 cycle: tile_we, tile_addr and tile_wdata are registered at the edge sampling in_valid and are valid for exactly one cycle.
- Audio: the word is written at the edge sampling the high byte, and sample_valid is high the following cycle. The FIFO is first-word-fall-through, so sample is valid whenever sample_valid is high.
- tiles_ready rises at the edge sampling the last tile byte.
- AUDIO_WAIT → AUDIO_REQ is decided on the registered FIFO count. A pop in the same cycle is not counted until the next cycle.

## Configuration
- AUDVID_AUDIO_LOOP_EN defined: at the end of the last audio block, blk_cnt resets to 0 and the FSM goes to AUDIO_WAIT, so audio loops indefinitely. Only Reset stops it.
- AUDVID_AUDIO_LOOP_EN not defined: at the end of the last audio block the FSM goes to DONE. busy=0 and the FIFO keeps draining. start in DONE behaves as in IDLE.

## Structure
- audvid_pkg holds SD_BLOCK_BYTES=512, the loader state enum and the FIFO_REQ_FREE=256 threshold.
- Sub-module audvid_word_fifo: a synchronous FWFT FIFO with parameter DEPTH, 16-bit width, and push, pop, full, empty and count ports.
- The loader FSM, counters and byte pairing live in sd_asset_loader.

## Test plan
- Tile load, defaults, start pulse: 32 requests at addresses 0..31, each answered with ack plus 512 bytes of pattern i&0xFF. Expect 16384 tile writes with tile_addr 0..16383 and data matching the pattern. tiles_ready rises after byte 16383; the next rd_addr is 64.
- Audio pairing: bytes 0x34, 0x12 → sample 0x1234. sample_valid asserts one cycle after the 0x12 strobe.
- Flow control, FIFO_DEPTH=512, sample_ready=0: two audio blocks fill the FIFO with 512 words. No third rd_req appears until 256 pops have been registered.
- End of audio, AUDIO_BLOCKS=2: without the macro, DONE with busy=0 after block 65. With AUDVID_AUDIO_LOOP_EN, the next rd_addr is 64.
- Errors: an in_valid pulse in IDLE sets overflow; start while busy causes no address restart.
- Reset asserted mid-block in TILE_RX at byte 100: all outputs return to reset values asynchronously. A new start re-requests block 0.
